// File: rtl/sm_spin_ctrl_if.sv
// Lever/coin inputs, reel engine link and score/credit outputs of the spin controller.
// Pure wiring bundle, no latency of its own.
// No backpressure: every signal is a level or a single-cycle pulse.
interface sm_spin_ctrl_if #(
    parameter int SYM_W    = 3,
    parameter int CREDIT_W = 8
);
    logic                  lever;
    logic                  coin;
    logic [3*SYM_W-1:0]    reel_sym;
    logic [2:0]            reel_spin;
    logic                  busy;
    logic                  result_valid;
    logic                  win;
    logic [CREDIT_W-1:0]   payout;
    logic [CREDIT_W-1:0]   credits;

    // Controller side
    modport master (
        input  lever, coin, reel_sym,
        output reel_spin, busy, result_valid, win, payout, credits
    );

    // Environment side: lever/coin hardware and reel engine
    modport slave (
        output lever, coin, reel_sym,
        input  reel_spin, busy, result_valid, win, payout, credits
    );
endinterface

// File: rtl/sm_spin_ctrl.sv
// Spin sequencer and credit manager: timed three-reel spin, staggered stops, scoring, credit balance.
// Start edge to result_valid takes SPIN_CYC + 2*STAGGER_CYC + 1 cycles; busy drops RESULT_HOLD cycles later.
// No backpressure: lever edges outside IDLE are dropped, coins are accepted every cycle with saturation.
module sm_spin_ctrl #(
    parameter int SYM_W         = 3,
    parameter int CREDIT_W      = 8,
    parameter int START_CREDITS = 10,
    parameter int SPIN_CYC      = 1000,
    parameter int STAGGER_CYC   = 500,
    parameter int RESULT_HOLD   = 200
) (
    input  logic          clk,
    input  logic          rst,
    sm_spin_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, SPIN, STOP, EVAL, SHOW} state_t;

    // One timer serves every phase, so it is sized for the longest one.
    localparam int TMAX0 = (SPIN_CYC > STAGGER_CYC) ? SPIN_CYC : STAGGER_CYC;
    localparam int TMAX  = (TMAX0 > RESULT_HOLD) ? TMAX0 : RESULT_HOLD;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    // Timer counts down to zero inclusive, so loads are one less than the phase length.
    localparam logic [TMR_W-1:0] SPIN_LD = TMR_W'(SPIN_CYC - 1);
    localparam logic [TMR_W-1:0] STAG_LD = TMR_W'(STAGGER_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(RESULT_HOLD - 1);

    localparam logic [CREDIT_W:0]   CMAX     = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W-1:0] PAY_JACK = CREDIT_W'(50);
    localparam logic [CREDIT_W-1:0] PAY_TRIP = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] PAY_PAIR = CREDIT_W'(2);

    state_t              state, state_nx;
    logic [TMR_W-1:0]    tmr, tmr_nx;
    logic [1:0]          idx, idx_nx;
    logic [2:0]          spin, spin_nx;
    logic [SYM_W-1:0]    sym [3];
    logic [SYM_W-1:0]    sym_nx [3];
    logic                win, win_nx;
    logic [CREDIT_W-1:0] payout, payout_nx;
    logic                result_valid, result_valid_nx;
    logic [CREDIT_W-1:0] credits, credits_nx;
    logic                lever_q;

    logic                start;
    logic                debit;
    logic [CREDIT_W-1:0] score;
    logic [CREDIT_W-1:0] add;
    logic [CREDIT_W:0]   sum;

    assign start = bus.lever & ~lever_q;

    // Score the latched symbols; only consumed in EVAL.
    always_comb begin
        score = '0;
        if (sym[0] == sym[1] && sym[1] == sym[2]) begin
            score = (sym[0] == {SYM_W{1'b1}}) ? PAY_JACK : PAY_TRIP;
        end else if (sym[0] == sym[1]) begin
            score = PAY_PAIR;
        end
    end

    // Next-state, timer, reel and score logic.
    always_comb begin
        state_nx        = state;
        tmr_nx          = (tmr != '0) ? tmr - TMR_W'(1) : tmr;
        idx_nx          = idx;
        spin_nx         = spin;
        sym_nx          = sym;
        win_nx          = win;
        payout_nx       = payout;
        result_valid_nx = 1'b0;
        debit           = 1'b0;
        add             = '0;
        case (state)
            IDLE: begin
                // Balance check uses the pre-coin value.
                if (start && credits != '0) begin
                    debit     = 1'b1;
                    spin_nx   = 3'b111;
                    win_nx    = 1'b0;
                    payout_nx = '0;
                    tmr_nx    = SPIN_LD;
                    state_nx  = SPIN;
                end
            end
            SPIN: begin
                if (tmr == '0) begin
                    spin_nx[0] = 1'b0;
                    sym_nx[0]  = bus.reel_sym[SYM_W-1:0];
                    idx_nx     = 2'd1;
                    tmr_nx     = STAG_LD;
                    state_nx   = STOP;
                end
            end
            STOP: begin
                if (tmr == '0) begin
                    spin_nx[idx] = 1'b0;
                    sym_nx[idx]  = bus.reel_sym[idx*SYM_W +: SYM_W];
                    if (idx == 2'd2) begin
                        state_nx = EVAL;
                    end else begin
                        idx_nx = idx + 2'd1;
                        tmr_nx = STAG_LD;
                    end
                end
            end
            EVAL: begin
                add             = score;
                payout_nx       = score;
                win_nx          = (score != '0);
                result_valid_nx = 1'b1;
                tmr_nx          = HOLD_LD;
                state_nx        = SHOW;
            end
            SHOW: begin
                if (tmr == '0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Debit only happens with a non-zero balance, so the sum never underflows.
        sum = {1'b0, credits} + {{CREDIT_W{1'b0}}, bus.coin} + {1'b0, add}
              - {{CREDIT_W{1'b0}}, debit};
        credits_nx = (sum > CMAX) ? CMAX[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
    end

    // State and datapath registers; the lever history keeps running in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tmr          <= '0;
            idx          <= '0;
            spin         <= '0;
            sym[0]       <= '0;
            sym[1]       <= '0;
            sym[2]       <= '0;
            win          <= 1'b0;
            payout       <= '0;
            result_valid <= 1'b0;
            credits      <= CREDIT_W'(START_CREDITS);
            lever_q      <= 1'b0;
        end else begin
            state        <= state_nx;
            tmr          <= tmr_nx;
            idx          <= idx_nx;
            spin         <= spin_nx;
            sym          <= sym_nx;
            win          <= win_nx;
            payout       <= payout_nx;
            result_valid <= result_valid_nx;
            credits      <= credits_nx;
            lever_q      <= bus.lever;
        end
    end

    assign bus.reel_spin    = spin;
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = result_valid;
    assign bus.win          = win;
    assign bus.payout       = payout;
    assign bus.credits      = credits;
endmodule

// File: tb/tb_sm_spin_ctrl.sv
// Bench for sm_spin_ctrl with short timing parameters.
// Spins are launched from a vector table; results are checked from a scoreboard queue.
// Hand sequences cover empty balance, saturation and reset mid-spin.
module tb_sm_spin_ctrl;
    localparam int SW = 3;
    localparam int CW = 8;
    localparam int START = 2;
    localparam int LAT = 20 + 2 * 10 + 1;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;
    int   model;
    int   rv_count;

    typedef struct {
        int payout;
        int win;
        int credits;
        int start;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        int s0, s1, s2;
        int pay;
        int coin;
        int hold;
        int pulses;
    } vec_t;
    vec_t tbl[8];

    sm_spin_ctrl_if #(.SYM_W(SW), .CREDIT_W(CW)) bus ();

    sm_spin_ctrl #(
        .SYM_W(SW), .CREDIT_W(CW), .START_CREDITS(START),
        .SPIN_CYC(20), .STAGGER_CYC(10), .RESULT_HOLD(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Scoreboard consumer: every result strobe must match the oldest launched spin.
    always @(negedge clk) begin
        if (!rst && bus.result_valid) begin
            rv_count++;
            if (sb_q.size() == 0) begin
                chk("rv_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("payout", bus.payout, mon_e.payout);
                chk("win", bus.win, mon_e.win);
                chk("credits_at_rv", bus.credits, mon_e.credits);
                chk("rv_latency", cyc - mon_e.start, LAT);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.lever = 1'b0;
        bus.coin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model = START;
    endtask

    // One full spin: symbols only carry their target value on the cycle before each stop edge.
    task automatic do_spin(input int s0, input int s1, input int s2, input int pay,
                           input int coin_rv, input int hold, input int pulses);
        logic [2:0] t0, t1, t2, j0, j1, j2;
        int rv_c, fin;
        sb_t e;
        t0 = 3'(s0); t1 = 3'(s1); t2 = 3'(s2);
        j0 = t0 ^ 3'b100; j1 = t1 ^ 3'b100; j2 = t2 ^ 3'b100;
        rv_c = sat(model - 1 + pay + coin_rv);
        fin  = coin_rv != 0 ? sat(rv_c + 1) : rv_c;
        @(negedge clk);
        bus.lever = 1'b1;
        bus.reel_sym = {j2, j1, j0};
        e.payout = pay;
        e.win = (pay != 0) ? 1 : 0;
        e.credits = rv_c;
        e.start = cyc + 1;
        sb_q.push_back(e);
        for (int off = 0; off <= 49; off++) begin
            @(negedge clk);
            if (off == 0) begin
                if (hold == 0) bus.lever = 1'b0;
                chk("start_busy", bus.busy, 1);
                chk("start_reels", bus.reel_spin, 3'b111);
                chk("start_debit", bus.credits, model - 1);
            end
            if (pulses != 0 && (off == 5 || off == 12)) bus.lever = 1'b1;
            if (pulses != 0 && (off == 6 || off == 13)) bus.lever = 1'b0;
            bus.reel_sym = {(off == 39) ? t2 : j2, (off == 29) ? t1 : j1, (off == 19) ? t0 : j0};
            bus.coin = (coin_rv != 0 && (off == 40 || off == 41));
            case (off)
                19: chk("reels_19", bus.reel_spin, 3'b111);
                20: chk("reels_20", bus.reel_spin, 3'b110);
                29: chk("reels_29", bus.reel_spin, 3'b110);
                30: chk("reels_30", bus.reel_spin, 3'b100);
                39: chk("reels_39", bus.reel_spin, 3'b100);
                40: chk("reels_40", bus.reel_spin, 3'b000);
                48: chk("busy_hold", bus.busy, 1);
                49: begin
                    chk("busy_fall", bus.busy, 0);
                    chk("credits_end", bus.credits, fin);
                end
                default: ;
            endcase
        end
        if (hold != 0) begin
            repeat (3) @(negedge clk);
            chk("hold_no_respin", bus.busy, 0);
            bus.lever = 1'b0;
        end
        model = fin;
    endtask

    initial begin
        int rv_before;
        tbl[0] = '{7, 7, 7, 50, 0, 0, 0};
        tbl[1] = '{3, 3, 5,  2, 0, 0, 0};
        tbl[2] = '{1, 2, 3,  0, 0, 0, 0};
        tbl[3] = '{4, 4, 4, 10, 0, 1, 0};
        tbl[4] = '{6, 6, 2,  2, 0, 0, 1};
        tbl[5] = '{5, 1, 5,  0, 0, 0, 0};
        tbl[6] = '{2, 5, 5,  0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 10, 0, 0, 0};

        n_pass = 0; n_total = 0; cyc = 0; rv_count = 0; model = START;
        rst = 1'b1;
        bus.lever = 1'b0;
        bus.coin = 1'b0;
        bus.reel_sym = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_reels", bus.reel_spin, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_win", bus.win, 0);
        chk("rst_payout", bus.payout, 0);
        chk("rst_credits", bus.credits, START);
        rst = 1'b0;

        // Table-driven spins
        for (int i = 0; i < 8; i++) begin
            do_spin(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].pay,
                    tbl[i].coin, tbl[i].hold, tbl[i].pulses);
        end

        // Empty balance: lever ignored; coin with lever adds credit but does not start
        do_reset();
        chk("rst2_credits", bus.credits, START);
        do_spin(1, 2, 3, 0, 0, 0, 0);
        do_spin(2, 3, 4, 0, 0, 0, 0);
        @(negedge clk);
        bus.lever = 1'b1;
        @(negedge clk);
        bus.lever = 1'b0;
        chk("empty_busy", bus.busy, 0);
        chk("empty_reels", bus.reel_spin, 0);
        repeat (3) @(negedge clk);
        chk("empty_busy_later", bus.busy, 0);
        chk("empty_credits", bus.credits, 0);
        @(negedge clk);
        bus.lever = 1'b1;
        bus.coin = 1'b1;
        @(negedge clk);
        bus.lever = 1'b0;
        bus.coin = 1'b0;
        chk("coinlever_busy", bus.busy, 0);
        chk("coinlever_credits", bus.credits, 1);
        repeat (2) @(negedge clk);
        chk("coinlever_busy_later", bus.busy, 0);
        model = 1;

        // Saturation: fill to 250 with coins, then win with coins around the result edge
        for (int i = 0; i < 249; i++) begin
            @(negedge clk);
            bus.coin = 1'b1;
        end
        @(negedge clk);
        bus.coin = 1'b0;
        chk("coins_250", bus.credits, 250);
        model = 250;
        do_spin(4, 4, 4, 10, 1, 0, 0);
        do_spin(7, 7, 7, 50, 0, 0, 0);
        chk("sat_255", bus.credits, 255);

        // Reset while reel 1 still spins
        @(negedge clk);
        bus.lever = 1'b1;
        @(negedge clk);
        bus.lever = 1'b0;
        repeat (25) @(negedge clk);
        chk("mid_reels", bus.reel_spin, 3'b110);
        rv_before = rv_count;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_reels", bus.reel_spin, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_credits", bus.credits, START);
        chk("midrst_rv", bus.result_valid, 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("midrst_no_rv", rv_count, rv_before);
        chk("midrst_idle", bus.busy, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
